// File: rtl/ls_station.sv
// In-order load/store reservation station: 4-entry circular buffer, head-only issue, CDB wakeup.
// Optional: define LS_WAKEUP_BYPASS_EN to capture a same-cycle CDB broadcast at dispatch.
module ls_station (
    input  logic        clk,
    input  logic        rst,
    input  logic        dis_valid,
    input  logic        dis_mem_wen,
    input  logic        dis_mem_ren,
    input  logic [5:0]  dis_p_rs,
    input  logic [5:0]  dis_p_rt,
    input  logic        dis_rs_rdy,
    input  logic        dis_rt_rdy,
    input  logic [15:0] dis_immed,
    input  logic [3:0]  dis_rob,
    input  logic [5:0]  dis_p_rd,
    input  logic        cdb_valid,
    input  logic [5:0]  cdb_tag,
    input  logic        sq_full,
    input  logic        stall_hazard,
    input  logic        recover,
    input  logic [3:0]  rec_rob,
    output logic        ls_full,
    output logic        issue,
    output logic        mem_wen,
    output logic        mem_ren,
    output logic [15:0] immed,
    output logic [3:0]  rob_out,
    output logic [5:0]  p_rd_out,
    output logic [5:0]  p_rs_out,
    output logic [5:0]  p_rt_out
);

    typedef struct packed {
        logic        valid;
        logic        wen;
        logic        ren;
        logic [5:0]  p_rs;
        logic        rs_rdy;
        logic [5:0]  p_rt;
        logic        rt_rdy;
        logic [15:0] immed;
        logic [3:0]  rob;
        logic [5:0]  p_rd;
    } entry_t;

    entry_t      ent [4];
    logic [3:0]  head_oh, tail_oh, tail_m1_oh;
    logic [1:0]  head_idx, tail_idx, tail_m1;
    logic [2:0]  count;

    entry_t      head_e, dis_ent;
    logic        rs_hit, rt_hit, conflict, dis_acc, sel, rec_hit;

    always_comb begin
        rs_hit     = cdb_valid && (dis_p_rs == cdb_tag);
        rt_hit     = cdb_valid && (dis_p_rt == cdb_tag);
        tail_m1    = tail_idx - 2'd1;
        tail_m1_oh = {tail_oh[0], tail_oh[3:1]};
        head_e     = ent[head_idx];

        dis_ent        = '0;
        dis_ent.valid  = 1'b1;
        dis_ent.wen    = dis_mem_wen;
        dis_ent.ren    = dis_mem_ren;
        dis_ent.p_rs   = dis_p_rs;
        dis_ent.p_rt   = dis_p_rt;
        dis_ent.immed  = dis_immed;
        dis_ent.rob    = dis_rob;
        dis_ent.p_rd   = dis_p_rd;
`ifdef LS_WAKEUP_BYPASS_EN
        conflict       = 1'b0;
        dis_ent.rs_rdy = dis_rs_rdy || rs_hit;
        dis_ent.rt_rdy = dis_mem_ren || dis_rt_rdy || rt_hit;
`else
        // Without bypass a not-ready source matching the live broadcast would miss its wakeup; refuse it.
        conflict       = dis_valid && ((!dis_rs_rdy && rs_hit) ||
                                       (dis_mem_wen && !dis_rt_rdy && rt_hit));
        dis_ent.rs_rdy = dis_rs_rdy;
        dis_ent.rt_rdy = dis_mem_ren || dis_rt_rdy;
`endif
        ls_full = (count == 3'd4) || conflict;
        dis_acc = dis_valid && !ls_full && !recover && !stall_hazard;
        sel     = head_e.valid && head_e.rs_rdy && (head_e.rt_rdy || !head_e.wen) &&
                  !stall_hazard && !recover && !(head_e.wen && sq_full);
        rec_hit = recover && ent[tail_m1].valid && (ent[tail_m1].rob == rec_rob);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 4; i++) ent[i] <= '0;
            head_oh  <= 4'b0001;
            tail_oh  <= 4'b0001;
            head_idx <= '0;
            tail_idx <= '0;
            count    <= '0;
            issue    <= 1'b0;
            mem_wen  <= 1'b0;
            mem_ren  <= 1'b0;
            immed    <= '0;
            rob_out  <= '0;
            p_rd_out <= '0;
            p_rs_out <= '0;
            p_rt_out <= '0;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (ent[i].valid && cdb_valid) begin
                    if (ent[i].p_rs == cdb_tag) ent[i].rs_rdy <= 1'b1;
                    if (ent[i].p_rt == cdb_tag) ent[i].rt_rdy <= 1'b1;
                end
                if (sel && head_oh[i])        ent[i].valid <= 1'b0;
                if (rec_hit && tail_m1_oh[i]) ent[i].valid <= 1'b0;
                if (dis_acc && tail_oh[i])    ent[i] <= dis_ent;
            end

            if (rec_hit) begin
                tail_oh  <= tail_m1_oh;
                tail_idx <= tail_m1;
                count    <= count - 3'd1;
            end else begin
                if (dis_acc) begin
                    tail_oh  <= {tail_oh[2:0], tail_oh[3]};
                    tail_idx <= tail_idx + 2'd1;
                end
                if (sel) begin
                    head_oh  <= {head_oh[2:0], head_oh[3]};
                    head_idx <= head_idx + 2'd1;
                end
                count <= count + 3'(dis_acc) - 3'(sel);
            end

            issue   <= sel;
            mem_wen <= sel && head_e.wen;
            mem_ren <= sel && head_e.ren;
            if (sel) begin
                immed    <= head_e.immed;
                rob_out  <= head_e.rob;
                p_rd_out <= head_e.p_rd;
                p_rs_out <= head_e.p_rs;
                p_rt_out <= head_e.p_rt;
            end
        end
    end

endmodule

// File: tb/tb_ls_station.sv
// Self-checking bench for ls_station: directed scenarios plus randomized traffic against a queue model.
module tb_ls_station;

    logic        clk = 1'b0;
    logic        rst, dis_valid, dis_mem_wen, dis_mem_ren, dis_rs_rdy, dis_rt_rdy;
    logic [5:0]  dis_p_rs, dis_p_rt, dis_p_rd, cdb_tag;
    logic [15:0] dis_immed;
    logic [3:0]  dis_rob, rec_rob;
    logic        cdb_valid, sq_full, stall_hazard, recover;
    logic        ls_full, issue, mem_wen, mem_ren;
    logic [15:0] immed;
    logic [3:0]  rob_out;
    logic [5:0]  p_rd_out, p_rs_out, p_rt_out;

    ls_station dut (
        .clk(clk), .rst(rst), .dis_valid(dis_valid), .dis_mem_wen(dis_mem_wen),
        .dis_mem_ren(dis_mem_ren), .dis_p_rs(dis_p_rs), .dis_p_rt(dis_p_rt),
        .dis_rs_rdy(dis_rs_rdy), .dis_rt_rdy(dis_rt_rdy), .dis_immed(dis_immed),
        .dis_rob(dis_rob), .dis_p_rd(dis_p_rd), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .sq_full(sq_full), .stall_hazard(stall_hazard), .recover(recover), .rec_rob(rec_rob),
        .ls_full(ls_full), .issue(issue), .mem_wen(mem_wen), .mem_ren(mem_ren),
        .immed(immed), .rob_out(rob_out), .p_rd_out(p_rd_out), .p_rs_out(p_rs_out),
        .p_rt_out(p_rt_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       wen;
        bit       rs_rdy, rt_rdy;
        bit [5:0] p_rs, p_rt, p_rd;
        bit [15:0] immed;
        bit [3:0] rob;
    } op_t;

    op_t      q[$];
    bit       e_issue, e_wen, e_ren;
    bit [15:0] e_immed;
    bit [3:0] e_rob;
    bit [5:0] e_rd, e_rs, e_rt;
    int       n_vec = 0, n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idle();
        dis_valid = 0; dis_mem_wen = 0; dis_mem_ren = 0; dis_rs_rdy = 0; dis_rt_rdy = 0;
        dis_p_rs = 0; dis_p_rt = 0; dis_p_rd = 0; dis_immed = 0; dis_rob = 0;
        cdb_valid = 0; cdb_tag = 0; stall_hazard = 0; recover = 0; rec_rob = 0; rst = 0;
    endtask

    task automatic disp(input bit st, input bit [3:0] rob, input bit [5:0] prs, input bit rsr,
                        input bit [5:0] prt, input bit rtr, input bit [15:0] imm);
        dis_valid = 1; dis_mem_wen = st; dis_mem_ren = !st; dis_rob = rob;
        dis_p_rs = prs; dis_rs_rdy = rsr; dis_p_rt = prt; dis_rt_rdy = rtr;
        dis_immed = imm; dis_p_rd = 6'(rob) + 6'd32;
    endtask

    // One clock: check combinational outputs, advance the model, then check registered outputs.
    task automatic step();
        bit conflict, full_e, sel, acc;
        op_t h, n, t;
        #1;
        conflict = dis_valid && cdb_valid &&
                   ((!dis_rs_rdy && dis_p_rs == cdb_tag) ||
                    (dis_mem_wen && !dis_rt_rdy && dis_p_rt == cdb_tag));
`ifdef LS_WAKEUP_BYPASS_EN
        conflict = 0;
`endif
        full_e = (q.size() == 4) || conflict;
        check("ls_full", ls_full, full_e);
        check("count", dut.count, q.size());
        sel = 0;
        if (q.size() > 0) begin
            h = q[0];
            sel = h.rs_rdy && (h.rt_rdy || !h.wen) && !stall_hazard && !recover &&
                  !(h.wen && sq_full);
        end
        acc = dis_valid && !full_e && !recover && !stall_hazard;
        if (rst) begin
            q.delete();
            {e_issue, e_wen, e_ren, e_immed, e_rob, e_rd, e_rs, e_rt} = '0;
        end else begin
            n.wen = dis_mem_wen; n.p_rs = dis_p_rs; n.p_rt = dis_p_rt; n.p_rd = dis_p_rd;
            n.immed = dis_immed; n.rob = dis_rob;
            n.rs_rdy = dis_rs_rdy; n.rt_rdy = dis_rt_rdy || dis_mem_ren;
`ifdef LS_WAKEUP_BYPASS_EN
            if (cdb_valid && dis_p_rs == cdb_tag) n.rs_rdy = 1;
            if (cdb_valid && dis_p_rt == cdb_tag) n.rt_rdy = 1;
`endif
            if (cdb_valid)
                foreach (q[i]) begin
                    t = q[i];
                    if (t.p_rs == cdb_tag) t.rs_rdy = 1;
                    if (t.p_rt == cdb_tag) t.rt_rdy = 1;
                    q[i] = t;
                end
            if (recover) begin
                if (q.size() > 0 && q[q.size()-1].rob == rec_rob) void'(q.pop_back());
            end else begin
                if (sel) begin
                    void'(q.pop_front());
                    e_immed = h.immed; e_rob = h.rob; e_rd = h.p_rd; e_rs = h.p_rs; e_rt = h.p_rt;
                end
                if (acc) q.push_back(n);
            end
            e_issue = sel; e_wen = sel && h.wen; e_ren = sel && !h.wen;
        end
        @(posedge clk);
        #1;
        check("issue", issue, e_issue);
        check("mem_wen", mem_wen, e_wen);
        check("mem_ren", mem_ren, e_ren);
        check("immed", immed, e_immed);
        check("rob_out", rob_out, e_rob);
        check("p_rd_out", p_rd_out, e_rd);
        check("p_rs_out", p_rs_out, e_rs);
        check("p_rt_out", p_rt_out, e_rt);
    endtask

    initial begin
        idle(); sq_full = 0; rst = 1;
        repeat (2) @(posedge clk);
        #1;
        step();
        idle();

        // Ready load: issue two edges after dispatch.
        disp(0, 4'd3, 6'd1, 1, 6'd0, 0, 16'h0010); step(); idle();
        check("ld_early", issue, 0);
        step();
        check("ld_issue", issue, 1);
        check("ld_ren", mem_ren, 1);
        check("ld_rob", rob_out, 3);
        check("ld_imm", immed, 16'h0010);
        step();

        // Store waiting on p_rt=12.
        disp(1, 4'd1, 6'd2, 1, 6'd12, 0, 16'h0100); step(); idle();
        step(); check("st_wait1", issue, 0);
        step(); check("st_wait2", issue, 0);
        cdb_valid = 1; cdb_tag = 6'd12; step(); idle();
        check("st_wait3", issue, 0);
        step();
        check("st_issue", issue, 1);
        check("st_wen", mem_wen, 1);
        step();

        // Four ready stores blocked by sq_full, fifth refused, then drain in order.
        sq_full = 1;
        for (int k = 0; k < 4; k++) begin
            disp(1, 4'(k), 6'd3, 1, 6'd4, 1, 16'(k)); step();
        end
        disp(1, 4'd9, 6'd3, 1, 6'd4, 1, 16'h9);
        #1 check("full_flag", ls_full, 1);
        step(); idle();
        check("full_noissue", issue, 0);
        sq_full = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            check("drain_issue", issue, 1);
            check("drain_rob", rob_out, 4'(k));
        end
        step();
        check("drain_done", issue, 0);

        // Recovery walks back youngest-first.
        disp(1, 4'd5, 6'd20, 0, 6'd4, 1, 16'h5); step();
        disp(0, 4'd6, 6'd4, 1, 6'd0, 0, 16'h6); step();
        disp(0, 4'd7, 6'd4, 1, 6'd0, 0, 16'h7); step(); idle();
        recover = 1; rec_rob = 4'd7; step();
        check("rec_cnt2", dut.count, 2);
        rec_rob = 4'd6; step();
        check("rec_cnt1", dut.count, 1);
        rec_rob = 4'd2; step(); idle();
        check("rec_noop", dut.count, 1);
        cdb_valid = 1; cdb_tag = 6'd20; step(); idle();
        step();
        check("rec_issue", issue, 1);
        check("rec_rob", rob_out, 5);
        repeat (2) step();

        // Dispatch colliding with a same-cycle broadcast.
        disp(0, 4'd10, 6'd30, 0, 6'd0, 0, 16'h30); cdb_valid = 1; cdb_tag = 6'd30;
`ifdef LS_WAKEUP_BYPASS_EN
        #1 check("byp_full", ls_full, 0);
        step(); idle();
        step();
        check("byp_issue", issue, 1);
`else
        #1 check("nobyp_full", ls_full, 1);
        step(); idle();
        disp(0, 4'd10, 6'd30, 1, 6'd0, 0, 16'h30); step(); idle();
        step();
        check("retry_issue", issue, 1);
`endif
        check("bp_rob", rob_out, 10);
        step();

        // Reset with three entries pending.
        for (int k = 0; k < 3; k++) begin
            disp(1, 4'(k + 11), 6'd40, 0, 6'd41, 1, 16'h40); step();
        end
        idle(); rst = 1; step(); idle();
        check("rst_cnt", dut.count, 0);
        check("rst_full", ls_full, 0);
        check("rst_issue", issue, 0);
        cdb_valid = 1; cdb_tag = 6'd40; step(); idle();
        repeat (3) step();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            idle();
            rst          = ($urandom_range(0, 199) == 0);
            sq_full      = ($urandom_range(0, 3) == 0);
            stall_hazard = ($urandom_range(0, 9) == 0);
            recover      = ($urandom_range(0, 9) == 0);
            rec_rob      = (q.size() > 0 && $urandom_range(0, 1)) ? q[q.size()-1].rob
                                                                   : 4'($urandom_range(0, 15));
            cdb_valid    = ($urandom_range(0, 4) < 2);
            cdb_tag      = 6'($urandom_range(0, 7));
            if ($urandom_range(0, 4) < 3)
                disp(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                     6'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                     6'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                     16'($urandom));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ls_station.md
# ls_station

In-order load/store reservation station. It sits between rename/dispatch and the store queue, and holds up to 4 memory ops until their source physical registers are ready. It issues the oldest op to the store queue / data-memory stage, together with the register-file read tags for rs/rt. Wakeup comes from the CDB; recovery removes ops one ROB entry per cycle, youngest first.

## Interface
- No parameters; depth fixed at 4 entries; tags 6b; ROB ids 4b.
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- dis_valid  input  1  dispatch request
- dis_mem_wen / dis_mem_ren  input  1 / 1  store / load (exactly one high when dis_valid)
- dis_p_rs, dis_p_rt  input  6 / 6  source physical tags
- dis_rs_rdy, dis_rt_rdy  input  1 / 1  source ready at rename
- dis_immed  input  16  offset
- dis_rob  input  4  ROB id
- dis_p_rd  input  6  load destination tag
- cdb_valid, cdb_tag  input  1 / 6  completion broadcast
- sq_full  input  1  store queue full
- stall_hazard  input  1  global stall
- recover, rec_rob  input  1 / 4  ROB walk-back
- ls_full  output  1  station cannot accept dispatch
- issue, mem_wen, mem_ren  output  1 each  registered issue strobe and op type
- immed  output  16  registered
- rob_out, p_rd_out  output  4 / 6  registered
- p_rs_out, p_rt_out  output  6 / 6  registered regfile read tags

## Operation
- Circular buffer: one-hot head/tail, 2b head/tail index, 3b count; `ls_full = (count == 4)`.
- Entry fields: valid, wen, ren, p_rs, rs_rdy, p_rt, rt_rdy, immed, rob, p_rd.
- **Dispatch accepted** when `dis_valid && !ls_full && !recover && !stall_hazard`: write at tail, tail++, count++.
  - A store requires both rs and rt ready before it can issue.
  - A load requires only rs ready; its rt_rdy is forced to 1.
- **Wakeup:** every valid entry whose p_rs or p_rt equals cdb_tag while cdb_valid sets the matching rdy bit.
- **Issue select:** head only, no out-of-order. Selected when all hold:
  - head entry is valid;
  - rs_rdy is set, and rt_rdy is set for a store;
  - `!stall_hazard && !recover`;
  - the op is not a store while sq_full is high.
- On select: head++, count--, entry invalidated.
- Dispatch and issue in the same cycle: count unchanged.
- **Recover:** when recover is high and the youngest valid entry (tail-1) has rob == rec_rob, that entry is invalidated, tail--, count--. No other entry is touched. No dispatch or issue occurs that cycle. A non-matching rec_rob is a no-op.
- Reset mid-operation: all entries invalid, head = tail = entry 0, count = 0, all outputs 0 on the next edge.

## Timing
- Issue outputs are registered: an op selected in cycle N drives issue=1 and its fields in cycle N+1.
  - issue deasserts the cycle after any non-select cycle.
  - The field outputs hold their last values when issue=0.
- Reset values: issue, mem_wen, mem_ren = 0; immed, rob_out, p_rd_out, p_rs_out, p_rt_out = 0; ls_full = 0.
- Minimum dispatch-to-issue latency for an op with ready operands into an empty station: dispatch edge N, select in N+1, issue high in N+2.
- Wakeup at cycle N (cdb_valid) makes the entry selectable in cycle N+1.
- Back-to-back: one issue per cycle sustained while operands are ready.
- Wrap-around: indices wrap 3→0, and the one-hot rotates identically.
- When full, dispatch is rejected; ls_full is combinational from count.

## Configuration
- `LS_WAKEUP_BYPASS_EN` defined: a CDB broadcast in the same cycle as an accepted dispatch whose dis_p_rs / dis_p_rt matches cdb_tag writes that source as ready.
- Undefined: no bypass. Instead, a dispatch whose not-ready source matches a concurrent CDB broadcast is refused that cycle; ls_full is also asserted that cycle so dispatch retries. No wakeup is ever lost.

## Test plan
- Reset, then dispatch a load with rs_rdy=1, rob=3, immed=0x0010 → issue=1, mem_ren=1, rob_out=3, immed=0x0010 two cycles after dispatch.
- Dispatch a store with rt_rdy=0 and p_rt=12; broadcast cdb_tag=12 three cycles later → issue=1, mem_wen=1 two cycles after the broadcast, not earlier.
- Fill with 4 ready stores while sq_full=1 → ls_full=1, issue stays 0, a 5th dispatch is refused. Drop sq_full → 4 consecutive issue pulses in order rob 0,1,2,3.
- Dispatch rob 5,6,7 (rob 5 not ready), then recover with rec_rob=7 then 6 → count goes 3→2→1; after wakeup only rob 5 issues.
- Dispatch with a same-cycle matching CDB → with `LS_WAKEUP_BYPASS_EN`, accepted and issued 2 cycles later; without it, ls_full=1 that cycle and the op is accepted on retry.
- Assert rst with 3 entries valid → next cycle count=0, ls_full=0, issue=0, and no stale entry issues after reset.
